// File: rtl/rib_pkg.sv
// Shared RIB bus constants: bus widths, access-type encodings and the error read pattern.
package rib_pkg;

    localparam int unsigned RIB_AW = 32;
    localparam int unsigned RIB_DW = 32;
    localparam int unsigned RIB_MW = 4;

    localparam logic RIB_WRITE = 1'b1;
    localparam logic RIB_READ  = 1'b0;

    localparam logic [RIB_DW-1:0] RIB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rib_rsp_fifo.sv
// Two-entry response buffer holding stage-1 results while the master applies back-pressure.
module rib_rsp_fifo
    import rib_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              push,
    input  logic              pop,
    input  logic [RIB_DW-1:0] wdata,
    output logic [RIB_DW-1:0] head,
    output logic [1:0]        cnt
);

    logic [RIB_DW-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        cnt_q;

    // Storage, pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign cnt  = cnt_q;

endmodule

// File: rtl/rib_sram_slave.sv
// RIB slave endpoint driving a single-port synchronous SRAM with one-cycle read latency.
// Optional feature: define RIB_SRAM_RANGE_CHK_EN to flag out-of-range accesses on o_err.
module rib_sram_slave
    import rib_pkg::*;
#(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [RIB_AW-1:0] i_ribs_addr,
    input  logic              i_ribs_wrcs,
    input  logic [RIB_MW-1:0] i_ribs_mask,
    input  logic [RIB_DW-1:0] i_ribs_wdata,
    output logic [RIB_DW-1:0] o_ribs_rdata,
    input  logic              i_ribs_req,
    output logic              o_ribs_gnt,
    output logic              o_ribs_rsp,
    input  logic              i_ribs_rdy,
    output logic              o_sram_ce,
    output logic              o_sram_we,
    output logic [RIB_MW-1:0] o_sram_be,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [RIB_DW-1:0] o_sram_wdata,
    input  logic [RIB_DW-1:0] i_sram_rdata
`ifdef RIB_SRAM_RANGE_CHK_EN
    ,
    output logic              o_err
`endif
);

    logic              accept;
    logic              oor;
    logic              s1_vld_q;
    logic              s1_wr_q;
    logic              s1_oor_q;
    logic [RIB_DW-1:0] s1_data;
    logic              buf_push;
    logic              buf_pop;
    logic              buf_empty;
    logic [1:0]        buf_cnt;
    logic [RIB_DW-1:0] buf_head;
    logic              unused_addr;

`ifdef RIB_SRAM_RANGE_CHK_EN
    logic err_q;
    assign oor         = |i_ribs_addr[23:ADDR_W+2];
    assign unused_addr = ^{i_ribs_addr[31:24], i_ribs_addr[1:0]};
`else
    assign oor         = 1'b0;
    assign unused_addr = ^{i_ribs_addr[31:ADDR_W+2], i_ribs_addr[1:0]};
`endif

    // Grant depends only on occupancy so the master never sees a rdy->gnt path.
    assign o_ribs_gnt = ({1'b0, buf_cnt} + {2'b0, s1_vld_q}) <= 3'd1;
    // Reset gates the accept so nothing reaches the SRAM while i_rstn is low.
    assign accept     = i_ribs_req & o_ribs_gnt & i_rstn;

    // Combinational SRAM drive in the accept cycle; out-of-range accesses are suppressed.
    always_comb begin
        o_sram_ce    = accept & ~oor;
        o_sram_we    = accept & ~oor & (i_ribs_wrcs == RIB_WRITE);
        o_sram_be    = (i_ribs_wrcs == RIB_WRITE) ? i_ribs_mask : 4'hF;
        o_sram_addr  = i_ribs_addr[ADDR_W+1:2];
        o_sram_wdata = i_ribs_wdata;
    end

    // Stage-1 register tracks the access whose SRAM data arrives this cycle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_vld_q <= 1'b0;
            s1_wr_q  <= 1'b0;
            s1_oor_q <= 1'b0;
        end else begin
            s1_vld_q <= accept;
            s1_wr_q  <= i_ribs_wrcs;
            s1_oor_q <= oor;
        end
    end

`ifdef RIB_SRAM_RANGE_CHK_EN
    // Sticky range-error flag, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            err_q <= 1'b0;
        end else if (accept && oor) begin
            err_q <= 1'b1;
        end
    end
    assign o_err = err_q;
`endif

    // Stage-1 result, buffer control and response mux; buffer head always has priority.
    always_comb begin
        s1_data = '0;
        if (s1_wr_q == RIB_READ) begin
            s1_data = s1_oor_q ? RIB_ERR_DATA : i_sram_rdata;
        end
        buf_empty    = (buf_cnt == 2'd0);
        buf_push     = s1_vld_q & (~buf_empty | ~i_ribs_rdy);
        buf_pop      = ~buf_empty & i_ribs_rdy;
        o_ribs_rsp   = ~buf_empty | s1_vld_q;
        o_ribs_rdata = '0;
        if (!buf_empty) begin
            o_ribs_rdata = buf_head;
        end else if (s1_vld_q) begin
            o_ribs_rdata = s1_data;
        end
    end

    rib_rsp_fifo u_rsp_fifo (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .push   (buf_push),
        .pop    (buf_pop),
        .wdata  (s1_data),
        .head   (buf_head),
        .cnt    (buf_cnt)
    );

endmodule

// File: tb/tb_rib_sram_slave.sv
// Directed self-checking bench for rib_sram_slave with a behavioural synchronous SRAM.
module tb_rib_sram_slave;

    localparam int unsigned ADDR_W = 14;

    logic              clk;
    logic              rstn;
    logic [31:0]       addr;
    logic              wrcs;
    logic [3:0]        mask;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              req;
    logic              gnt;
    logic              rsp;
    logic              rdy;
    logic              sram_ce;
    logic              sram_we;
    logic [3:0]        sram_be;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_wdata;
    logic [31:0]       sram_rdata;
`ifdef RIB_SRAM_RANGE_CHK_EN
    logic              err;
`endif

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    int errors = 0;
    int checks = 0;

    rib_sram_slave #(.ADDR_W(ADDR_W)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_ribs_addr  (addr),
        .i_ribs_wrcs  (wrcs),
        .i_ribs_mask  (mask),
        .i_ribs_wdata (wdata),
        .o_ribs_rdata (rdata),
        .i_ribs_req   (req),
        .o_ribs_gnt   (gnt),
        .o_ribs_rsp   (rsp),
        .i_ribs_rdy   (rdy),
        .o_sram_ce    (sram_ce),
        .o_sram_we    (sram_we),
        .o_sram_be    (sram_be),
        .o_sram_addr  (sram_addr),
        .o_sram_wdata (sram_wdata),
        .i_sram_rdata (sram_rdata)
`ifdef RIB_SRAM_RANGE_CHK_EN
        ,
        .o_err        (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: byte-masked write, registered read.
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are then driven just after the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] bp_exp [4];
    int acc;
    int got_n;
    int stale;

    initial begin
        rstn  = 1'b0;
        req   = 1'b1;
        wrcs  = 1'b0;
        addr  = 32'h14;
        mask  = 4'h0;
        wdata = 32'h0;
        rdy   = 1'b1;
        sram_rdata = 32'h0;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
        mem[5] = 32'h1234_5678;
        for (int i = 0; i < 8; i++) mem[16+i] = 32'hC0DE_0000 + i;
        for (int i = 0; i < 4; i++) mem[32+i] = 32'hA0 + i;

        // Reset: no SRAM access even with req high
        @(negedge clk); @(negedge clk); #1;
        check("rst_ce", {31'b0, sram_ce}, 32'h0);
        check("rst_rsp", {31'b0, rsp}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
`ifdef RIB_SRAM_RANGE_CHK_EN
        check("rst_err", {31'b0, err}, 32'h0);
`endif
        @(negedge clk);
        rstn = 1'b1; req = 1'b0; #1;
        check("rst_gnt", {31'b0, gnt}, 32'h1);
        check("rst_we", {31'b0, sram_we}, 32'h0);

        // Single read latency
        tick();
        req = 1'b1; wrcs = 1'b0; addr = 32'h14; #1;
        check("rd_gnt", {31'b0, gnt}, 32'h1);
        check("rd_ce", {31'b0, sram_ce}, 32'h1);
        check("rd_be", {28'b0, sram_be}, 32'hF);
        check("rd_addr", {18'b0, sram_addr}, 32'd5);
        tick();
        req = 1'b0; #1;
        check("rd_rsp", {31'b0, rsp}, 32'h1);
        check("rd_data", rdata, 32'h1234_5678);
        tick(); #1;
        check("rd_rsp_once", {31'b0, rsp}, 32'h0);

        // Byte-masked write then read back
        req = 1'b1; wrcs = 1'b1; addr = 32'h20; mask = 4'b0101; wdata = 32'hAABB_CCDD; #1;
        check("wr_we", {31'b0, sram_we}, 32'h1);
        check("wr_be", {28'b0, sram_be}, 32'h5);
        tick();
        req = 1'b1; wrcs = 1'b0; addr = 32'h20; #1;
        check("wr_rsp", {31'b0, rsp}, 32'h1);
        check("wr_rdata", rdata, 32'h0);
        tick();
        req = 1'b0; #1;
        check("wr_readback", rdata, 32'h00BB_00DD);
        tick();

        // Back-to-back stream of 8 reads
        for (int i = 0; i < 9; i++) begin
            req = (i < 8); wrcs = 1'b0; addr = 32'((16 + i) * 4); #1;
            if (i < 8) check($sformatf("st_gnt%0d", i), {31'b0, gnt}, 32'h1);
            if (i > 0) begin
                check($sformatf("st_rsp%0d", i - 1), {31'b0, rsp}, 32'h1);
                check($sformatf("st_data%0d", i - 1), rdata, 32'hC0DE_0000 + 32'(i - 1));
            end
            tick();
        end
        #1;
        check("st_idle", {31'b0, rsp}, 32'h0);

        // Back-pressure: 4 reads, rdy low
        bp_exp[0] = 32'hA0; bp_exp[1] = 32'hA1; bp_exp[2] = 32'hA2; bp_exp[3] = 32'hA3;
        rdy = 1'b0; req = 1'b1; addr = 32'd128; #1;
        check("bp_gnt0", {31'b0, gnt}, 32'h1);
        tick();
        addr = 32'd132; #1;
        check("bp_gnt1", {31'b0, gnt}, 32'h1);
        check("bp_rsp1", {31'b0, rsp}, 32'h1);
        check("bp_data1", rdata, 32'hA0);
        tick();
        addr = 32'd136; #1;
        check("bp_gnt_drop", {31'b0, gnt}, 32'h0);
        check("bp_hold_a", rdata, 32'hA0);
        tick(); #1;
        check("bp_gnt_low", {31'b0, gnt}, 32'h0);
        check("bp_hold_rsp", {31'b0, rsp}, 32'h1);
        check("bp_hold_b", rdata, 32'hA0);
        rdy = 1'b1;
        acc = 2; got_n = 0;
        for (int c = 0; c < 20; c++) begin
            req = (acc < 4); addr = 32'((32 + acc) * 4); #1;
            if (rsp) begin
                if (got_n < 4) check($sformatf("bp_data%0d", got_n), rdata, bp_exp[got_n]);
                got_n++;
            end
            if (req && gnt) acc++;
            tick();
        end
        check("bp_acc", 32'(acc), 32'd4);
        check("bp_count", 32'(got_n), 32'd4);

        // Reset with two responses outstanding
        rdy = 1'b0; req = 1'b1; addr = 32'h14; #1;
        tick();
        addr = 32'h20; #1;
        tick();
        rstn = 1'b0; #1;
        check("mr_rsp", {31'b0, rsp}, 32'h0);
        check("mr_ce", {31'b0, sram_ce}, 32'h0);
        tick();
        rstn = 1'b1; req = 1'b0; rdy = 1'b1; #1;
        check("mr_gnt", {31'b0, gnt}, 32'h1);
        stale = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (rsp) stale++;
            tick();
        end
        check("mr_stale", 32'(stale), 32'd0);

`ifdef RIB_SRAM_RANGE_CHK_EN
        // Out-of-range read then in-range read; error stays sticky
        req = 1'b1; wrcs = 1'b0; addr = 32'h0010_0000; #1;
        check("oor_gnt", {31'b0, gnt}, 32'h1);
        check("oor_ce", {31'b0, sram_ce}, 32'h0);
        check("oor_err0", {31'b0, err}, 32'h0);
        tick();
        addr = 32'h14; #1;
        check("oor_rdata", rdata, 32'hDEAD_BEEF);
        check("oor_err1", {31'b0, err}, 32'h1);
        check("inr_ce", {31'b0, sram_ce}, 32'h1);
        tick();
        req = 1'b0; #1;
        check("inr_rdata", rdata, 32'h1234_5678);
        check("oor_err2", {31'b0, err}, 32'h1);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rib_sram_slave.md
# rib_sram_slave

RIB slave endpoint that terminates one slave port of the RIB slave-select stage and drives a single-port synchronous SRAM. It accepts one request per cycle and returns reads with one-cycle latency. A 2-entry response buffer absorbs master back-pressure (`rdy` low) without losing SRAM read data. It sits directly downstream of the address decoder, and is typically used for on-chip instruction/data RAM.

## Interface
- `ADDR_W`, default 14: SRAM word-address width; capacity 2^ADDR_W × 32 bit.
- `i_clk`  in  1: clock.
- `i_rstn`  in  1: reset, asynchronous, active-low.
- `i_ribs_addr`  in  32: byte address; upper 8 bits are already zeroed by the decoder.
- `i_ribs_wrcs`  in  1: access type; 1 = write, 0 = read.
- `i_ribs_mask`  in  4: byte-write enables; bit k covers `wdata[8k+7:8k]`.
- `i_ribs_wdata`  in  32: write data.
- `o_ribs_rdata`  out  32: read data; meaningful only while `o_ribs_rsp` = 1.
- `i_ribs_req`  in  1: request valid.
- `o_ribs_gnt`  out  1: request accepted this cycle when `req` & `gnt`.
- `o_ribs_rsp`  out  1: response valid.
- `i_ribs_rdy`  in  1: master consumes the response this cycle when `rsp` & `rdy`.
- `o_sram_ce`  out  1: SRAM access enable.
- `o_sram_we`  out  1: SRAM write enable.
- `o_sram_be`  out  4: SRAM byte enables.
- `o_sram_addr`  out  ADDR_W: SRAM word address.
- `o_sram_wdata`  out  32: SRAM write data.
- `i_sram_rdata`  in  32: SRAM read data; valid the cycle after `ce` with `we` = 0.
- `o_err`  out  1: sticky range-error flag. Present only with `RIB_SRAM_RANGE_CHK_EN`.

## Operation
- Accept condition: `req` & `gnt`. On accept, the block drives the SRAM combinationally in the same cycle:
  - `ce` = 1, `we` = `wrcs`, `be` = `wrcs ? mask : 4'hF`.
  - `addr` = `i_ribs_addr[ADDR_W+1:2]`; bits [1:0] are ignored.
- Without an accept: `ce` = 0 and `we` = 0.
- Stage-1 flag `s1_vld` is set on the cycle after each accept. The `wrcs` of that access is registered alongside it.
- Every accepted request produces exactly one response, in accept order. Writes respond with `rdata` = 0.
- Response source:
  - If the buffer is non-empty, the response comes from the buffer head.
  - Otherwise, if `s1_vld` = 1, it comes from stage 1: `rdata` = `i_sram_rdata` (read) or 0 (write).
  - `rsp` = buffer non-empty | `s1_vld`.
- Buffer push: a stage-1 result is pushed when `s1_vld` = 1 and it is not consumed this cycle, i.e. the buffer is non-empty or `rdy` = 0.
- Buffer pop: the head is popped when the buffer is non-empty and `rsp` & `rdy`.
- Push and pop may happen in the same cycle; the count is then unchanged.
- Grant rule: `gnt` = (`buf_cnt` + `s1_vld`) ≤ 1. It depends on state only; there is no combinational path from `rdy` or `req` to `gnt`.
- The grant rule guarantees the buffer never overflows. A push is never attempted when `buf_cnt` = 2.
- While `rsp` = 1 and `rdy` = 0, `rsp` and `rdata` stay stable until consumed.

## Timing
- Reset values: `o_ribs_rsp` = 0, `o_ribs_rdata` = 0, `o_sram_ce` = 0, `o_sram_we` = 0, `o_err` = 0, buffer empty, `s1_vld` = 0. `o_ribs_gnt` = 1 from the first cycle out of reset.
- Latency: accept in cycle N gives `rsp` in N+1 when the buffer is empty.
- Throughput: 1 transaction per cycle while `rdy` is held at 1.
- Back-pressure with `rdy` = 0:
  - `gnt` drops once 2 transactions are outstanding (buffer + stage 1).
  - After `rdy` returns, `gnt` reasserts the cycle after the occupancy falls to ≤ 1.
- Reset mid-operation: all outstanding responses are discarded. No SRAM access is issued during reset.

## Configuration
- `RIB_SRAM_RANGE_CHK_EN` defined:
  - Out-of-range access: accepted with `i_ribs_addr[23:ADDR_W+2]` ≠ 0.
  - It is still granted and still gets a response, but no SRAM access is issued (`ce` = 0).
  - A read returns `32'hDEAD_BEEF`.
  - `o_err` is set in the cycle after the accept and is held until reset.
- Undefined: address bits above ADDR_W+1 are ignored and the address aliases. The `o_err` port is absent.

## Structure
- Shared package `rib_pkg`:
  - `RIB_AW` = 32, `RIB_DW` = 32, `RIB_MW` = 4.
  - `RIB_WRITE` = 1'b1, `RIB_READ` = 1'b0.
  - `RIB_ERR_DATA` = 32'hDEAD_BEEF.
- Sub-module `rib_rsp_fifo`: 2-entry × 32-bit FIFO with push, pop, count, head and async reset. The top level holds the stage-1 register, the grant logic and the range check.

## Test plan
- Single-read latency: preload word 5 = `32'h1234_5678`; read `addr` 0x14 with `rdy` = 1. Expect `rsp` for exactly 1 cycle, one cycle after the accept, with `rdata` = `32'h1234_5678`.
- Byte-masked write: write `32'hAABB_CCDD`, `mask` = 4'b0101 to 0x20, which holds 0. Then read 0x20 and expect `32'h00BB_00DD`.
- Back-to-back stream: 8 reads to consecutive addresses with `req` and `rdy` held at 1. Expect `gnt` = 1 every cycle, 8 consecutive `rsp` cycles in order, and no bubbles.
- Back-pressure:
  - Issue 4 reads with `rdy` = 0; expect `gnt` to fall after the 2nd accept.
  - `rsp`/`rdata` hold the 1st result stable.
  - Raise `rdy` and expect all 4 responses in order with no loss or duplication.
- Reset during activity: assert `i_rstn` = 0 with 2 responses outstanding. Expect `rsp` = 0, `ce` = 0, `gnt` = 1 after release, and no stale response afterwards.
- With `RIB_SRAM_RANGE_CHK_EN` and `ADDR_W` = 14: read 0x10_0000.
  - Expect `ce` = 0 and `rdata` = `32'hDEAD_BEEF`.
  - `o_err` rises the next cycle and stays 1 across later in-range accesses.
